nn_eval_sequencer: RTL and testbench
====================================

// Module: nn_eval_sequencer
// PURPOSE
//  Synthesizable batch-inference sequencer and scoreboard for the NN core.
//  For each sample index it pulses the core's reset, holds start, and waits for done
//  or a timeout. It then compares the predicted label with the golden label from a
//  synchronous label ROM and accumulates correct, completed and timeout counts.
//  Sits between the control/host interface and one NN instance.
// PARAMETERS
//  IDX_W      16    width of sample index / count
//  LABEL_W    8     width of predicted and golden labels
//  CNT_W      32    width of result counters (saturating)
//  RST_CYC    2     cycles nn_rst is held high per sample (>=1)
//  TIMEOUT    8192  max cycles in RUN before a sample is declared timed out (>=2)
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous, active-low reset
//  run           in   1        start batch (sampled in IDLE only)
//  abort         in   1        cancel batch
//  sample_base   in   IDX_W    first sample index (latched on run)
//  sample_count  in   IDX_W    number of samples (latched on run)
//  nn_idx        out  IDX_W    sample index driven to NN core
//  nn_rst        out  1        active-high reset to NN core
//  nn_start      out  1        start level to NN core
//  nn_done       in   1        NN core result valid (level or pulse)
//  nn_label      in   LABEL_W  NN core predicted label
//  lbl_addr      out  IDX_W    golden-label ROM address (= nn_idx)
//  lbl_data      in   LABEL_W  ROM data, valid 1 cycle after lbl_addr
//  res_valid     out  1        1-cycle pulse per finished sample
//  res_match     out  1        sample correct (qualified by res_valid)
//  num_correct   out  CNT_W    correct samples in current batch
//  num_done      out  CNT_W    finished samples (incl. timeouts)
//  num_timeout   out  CNT_W    timed-out samples
//  busy          out  1        high from run acceptance until FINISH
//  done          out  1        1-cycle pulse at batch end
// BEHAVIOUR
//  Reset (rst=0): state IDLE; nn_rst=1, nn_start=0, busy=0, done=0, res_valid=0,
//   res_match=0, counters=0, nn_idx=lbl_addr=0.
//  IDLE: nn_rst=1. run=1 -> latch base/count, clear all counters, idx<=base,
//   k<=0, busy<=1; count==0 -> FINISH, else NN_RST.
//  NN_RST: nn_rst=1, nn_start=0 for RST_CYC cycles -> RUN; cycle counter cleared.
//  RUN: nn_rst=0, nn_start=1. nn_done=1 -> capture nn_label, -> COMPARE.
//   Cycle counter reaching TIMEOUT-1 with nn_done=0 -> TMO.
//   nn_done on the terminal cycle counts as done, not timeout.
//  COMPARE (1 cycle): nn_start=0; res_valid=1, res_match=(captured==lbl_data);
//   num_done++, num_correct+=match -> NEXT.
//  TMO (1 cycle): res_valid=1, res_match=0; num_done++, num_timeout++ -> NEXT.
//  NEXT: k++, idx++ (mod 2^IDX_W, wraps silently); k==count -> FINISH else NN_RST.
//  FINISH: done=1 for one cycle, busy<=0 -> IDLE. Counters hold until next run.
//  lbl_addr mirrors nn_idx and is stable >=RST_CYC+1 cycles before COMPARE.
//  run while busy is ignored. abort=1 in any non-IDLE state -> IDLE next cycle;
//   nn_rst=1, no done pulse, counters hold partial values; abort beats nn_done.
//  Counters saturate at all-ones; no wrap.
//  Async reset mid-batch returns everything to reset values at once.
// TESTING
//  base=0,count=4, NN model returns golden labels after 10 cycles -> 4 res_valid
//   pulses all match; num_correct=4, num_done=4, num_timeout=0, one done pulse.
//  count=3, model returns wrong label for idx 1 -> res_match 1,0,1; num_correct=2.
//  count=2, TIMEOUT=16, model never asserts done on idx 0 -> TMO after 16 RUN
//   cycles; num_timeout=1, num_done=2, num_correct<=1.
//  nn_done on exactly cycle TIMEOUT-1 -> counted as done, num_timeout=0.
//  base=16'hFFFF,count=2 -> nn_idx FFFF then 0000; count=0 -> done 2 cycles after run.
//  abort during RUN of sample 2 of 5 -> IDLE next cycle, no done, num_done=2;
//   rst=0 mid-batch -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/nn_eval_sequencer.sv
// Batch-inference sequencer for one NN core: resets and starts the core per sample,
// waits for done or timeout, scores the predicted label against a golden-label ROM.
module nn_eval_sequencer #(
    parameter int IDX_W   = 16,
    parameter int LABEL_W = 8,
    parameter int CNT_W   = 32,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 8192
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               abort,
    input  logic [IDX_W-1:0]   sample_base,
    input  logic [IDX_W-1:0]   sample_count,
    output logic [IDX_W-1:0]   nn_idx,
    output logic               nn_rst,
    output logic               nn_start,
    input  logic               nn_done,
    input  logic [LABEL_W-1:0] nn_label,
    output logic [IDX_W-1:0]   lbl_addr,
    input  logic [LABEL_W-1:0] lbl_data,
    output logic               res_valid,
    output logic               res_match,
    output logic [CNT_W-1:0]   num_correct,
    output logic [CNT_W-1:0]   num_done,
    output logic [CNT_W-1:0]   num_timeout,
    output logic               busy,
    output logic               done
);

    localparam int CYC_W = $clog2(TIMEOUT + RST_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYC - 1);
    localparam logic [CYC_W-1:0] RUN_LAST = CYC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NN_RST  = 3'd1,
        S_RUN     = 3'd2,
        S_COMPARE = 3'd3,
        S_TMO     = 3'd4,
        S_NEXT    = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   count_r;
    logic [IDX_W-1:0]   k_r;
    logic [CYC_W-1:0]   cyc_r;
    logic [LABEL_W-1:0] label_r;
    logic               nn_rst_r;
    logic               nn_start_r;
    logic               res_valid_r;
    logic               res_match_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   num_correct_r;
    logic [CNT_W-1:0]   num_done_r;
    logic [CNT_W-1:0]   num_timeout_r;
    logic               match_s;
    logic               live_s;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state decode; abort overrides everything outside IDLE, including nn_done.
    always_comb begin
        state_s = state_r;
        match_s = (label_r == lbl_data);
        live_s  = !(abort && (state_r != S_IDLE));
        if (!live_s) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (run) begin
                        state_s = (sample_count == IDX_ZERO) ? S_FINISH : S_NN_RST;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_NN_RST: begin
                    if (cyc_r == RST_LAST) begin
                        state_s = S_RUN;
                    end else begin
                        state_s = S_NN_RST;
                    end
                end
                S_RUN: begin
                    if (nn_done) begin
                        state_s = S_COMPARE;
                    end else if (cyc_r == RUN_LAST) begin
                        state_s = S_TMO;
                    end else begin
                        state_s = S_RUN;
                    end
                end
                S_COMPARE: state_s = S_NEXT;
                S_TMO:     state_s = S_NEXT;
                S_NEXT: begin
                    if ((k_r + IDX_ONE) == count_r) begin
                        state_s = S_FINISH;
                    end else begin
                        state_s = S_NN_RST;
                    end
                end
                S_FINISH: state_s = S_IDLE;
                default:  state_s = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sample bookkeeping: index, sample counter, per-state cycle counter, captured label.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r   <= IDX_ZERO;
            count_r <= IDX_ZERO;
            k_r     <= IDX_ZERO;
            cyc_r   <= {CYC_W{1'b0}};
            label_r <= {LABEL_W{1'b0}};
        end else begin
            if (state_r == S_IDLE && run) begin
                idx_r   <= sample_base;
                count_r <= sample_count;
                k_r     <= IDX_ZERO;
            end else if (state_r == S_NEXT && live_s) begin
                idx_r <= idx_r + IDX_ONE;
                k_r   <= k_r + IDX_ONE;
            end else begin
                idx_r <= idx_r;
                k_r   <= k_r;
            end
            if (state_s != state_r) begin
                cyc_r <= {CYC_W{1'b0}};
            end else if (state_r == S_NN_RST || state_r == S_RUN) begin
                cyc_r <= cyc_r + CYC_ONE;
            end else begin
                cyc_r <= cyc_r;
            end
            if (state_r == S_RUN && nn_done) begin
                label_r <= nn_label;
            end else begin
                label_r <= label_r;
            end
        end
    end

    // Core-control outputs track the state being entered; result outputs follow the scoring state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nn_rst_r    <= 1'b1;
            nn_start_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_match_r <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            nn_rst_r    <= (state_s != S_RUN);
            nn_start_r  <= (state_s == S_RUN);
            res_valid_r <= live_s && (state_r == S_COMPARE || state_r == S_TMO);
            res_match_r <= live_s && (state_r == S_COMPARE) && match_s;
            done_r      <= live_s && (state_r == S_FINISH);
            if (state_r == S_IDLE && run) begin
                busy_r <= 1'b1;
            end else if (!live_s || state_r == S_FINISH) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Result counters: cleared on run acceptance, held after finish or abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_correct_r <= {CNT_W{1'b0}};
            num_done_r    <= {CNT_W{1'b0}};
            num_timeout_r <= {CNT_W{1'b0}};
        end else if (state_r == S_IDLE && run) begin
            num_correct_r <= {CNT_W{1'b0}};
            num_done_r    <= {CNT_W{1'b0}};
            num_timeout_r <= {CNT_W{1'b0}};
        end else if (live_s && state_r == S_COMPARE) begin
            num_done_r    <= sat_inc(num_done_r);
            num_correct_r <= match_s ? sat_inc(num_correct_r) : num_correct_r;
            num_timeout_r <= num_timeout_r;
        end else if (live_s && state_r == S_TMO) begin
            num_done_r    <= sat_inc(num_done_r);
            num_timeout_r <= sat_inc(num_timeout_r);
            num_correct_r <= num_correct_r;
        end else begin
            num_correct_r <= num_correct_r;
            num_done_r    <= num_done_r;
            num_timeout_r <= num_timeout_r;
        end
    end

    assign nn_idx      = idx_r;
    assign lbl_addr    = idx_r;
    assign nn_rst      = nn_rst_r;
    assign nn_start    = nn_start_r;
    assign res_valid   = res_valid_r;
    assign res_match   = res_match_r;
    assign num_correct = num_correct_r;
    assign num_done    = num_done_r;
    assign num_timeout = num_timeout_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_nn_eval_sequencer.sv
// Directed bench for nn_eval_sequencer with a small NN-core / label-ROM responder.
module tb_nn_eval_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] sample_base = 16'h0000;
    logic [15:0] sample_count = 16'h0000;
    logic [15:0] nn_idx;
    logic        nn_rst;
    logic        nn_start;
    logic        nn_done;
    logic [7:0]  nn_label;
    logic [15:0] lbl_addr;
    logic [7:0]  lbl_data = 8'h00;
    logic        res_valid;
    logic        res_match;
    logic [31:0] num_correct;
    logic [31:0] num_done;
    logic [31:0] num_timeout;
    logic        busy;
    logic        done;

    nn_eval_sequencer #(.IDX_W(16), .LABEL_W(8), .CNT_W(32), .RST_CYC(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort),
        .sample_base(sample_base), .sample_count(sample_count),
        .nn_idx(nn_idx), .nn_rst(nn_rst), .nn_start(nn_start), .nn_done(nn_done),
        .nn_label(nn_label), .lbl_addr(lbl_addr), .lbl_data(lbl_data),
        .res_valid(res_valid), .res_match(res_match),
        .num_correct(num_correct), .num_done(num_done), .num_timeout(num_timeout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // NN core model: raises done after lat RUN cycles; can hang or mislabel one index.
    logic [15:0] lat = 16'd10;
    logic        hang_en = 1'b0;
    logic [15:0] hang_idx = 16'h0000;
    logic        bad_en = 1'b0;
    logic [15:0] bad_idx = 16'h0000;
    logic [15:0] run_cnt = 16'h0000;

    function automatic logic [7:0] gold(input logic [15:0] i);
        return i[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        lbl_data <= gold(lbl_addr);
        if (nn_rst) run_cnt <= 16'h0000;
        else if (nn_start) run_cnt <= run_cnt + 16'h0001;
    end

    assign nn_done  = nn_start && !nn_rst && !(hang_en && nn_idx == hang_idx) && (run_cnt == lat);
    assign nn_label = gold(nn_idx) ^ ((bad_en && nn_idx == bad_idx) ? 8'h01 : 8'h00);

    // Monitor: result pulses, batch-done pulses, index of each started sample.
    logic        match_q[$];
    logic [15:0] idx_q[$];
    int          ndone = 0;
    logic        start_d = 1'b0;

    always @(negedge clk) begin
        if (res_valid) match_q.push_back(res_match);
        if (done) ndone++;
        if (nn_start && !start_d) idx_q.push_back(nn_idx);
        start_d = nn_start;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_match(input string tag, input int n0, input int i, input logic exp);
        logic obs;
        obs = (n0 + i < match_q.size()) ? match_q[n0 + i] : 1'bx;
        check(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic start_batch(input logic [15:0] b, input logic [15:0] c);
        @(negedge clk);
        sample_base  = b;
        sample_count = c;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 2000 && busy; i++) @(negedge clk);
        check(tag, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    int m0;
    int d0;
    int q0;

    initial begin
        // Reset state
        #12;
        check("rst_nn_rst", {31'd0, nn_rst}, 32'd1);
        check("rst_nn_start", {31'd0, nn_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_num_done", num_done, 32'd0);
        check("rst_nn_idx", {16'd0, nn_idx}, 32'd0);
        check("rst_lbl_addr", {16'd0, lbl_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // All-correct batch of 4
        m0 = match_q.size(); d0 = ndone;
        start_batch(16'd0, 16'd4);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_idle("t1_wait");
        check("t1_nvalid", match_q.size() - m0, 32'd4);
        for (int i = 0; i < 4; i++) check_match("t1_match", m0, i, 1'b1);
        check("t1_correct", num_correct, 32'd4);
        check("t1_done", num_done, 32'd4);
        check("t1_timeout", num_timeout, 32'd0);
        check("t1_donepulse", ndone - d0, 32'd1);

        // Wrong label on the middle sample
        bad_en = 1'b1; bad_idx = 16'd9;
        m0 = match_q.size();
        start_batch(16'd8, 16'd3);
        wait_idle("t2_wait");
        check_match("t2_match0", m0, 0, 1'b1);
        check_match("t2_match1", m0, 1, 1'b0);
        check_match("t2_match2", m0, 2, 1'b1);
        check("t2_correct", num_correct, 32'd2);
        check("t2_done", num_done, 32'd3);
        bad_en = 1'b0;

        // First sample hangs and times out
        hang_en = 1'b1; hang_idx = 16'd20;
        m0 = match_q.size();
        start_batch(16'd20, 16'd2);
        wait_idle("t3_wait");
        check("t3_timeout", num_timeout, 32'd1);
        check("t3_done", num_done, 32'd2);
        check("t3_correct", num_correct, 32'd1);
        check_match("t3_match0", m0, 0, 1'b0);
        hang_en = 1'b0;

        // Done on the terminal RUN cycle wins over timeout
        lat = 16'(TIMEOUT - 1);
        start_batch(16'd30, 16'd1);
        wait_idle("t4_wait");
        check("t4_timeout", num_timeout, 32'd0);
        check("t4_correct", num_correct, 32'd1);

        // One cycle later is a timeout
        lat = 16'(TIMEOUT);
        start_batch(16'd30, 16'd1);
        wait_idle("t5_wait");
        check("t5_timeout", num_timeout, 32'd1);
        check("t5_correct", num_correct, 32'd0);
        lat = 16'd10;

        // Index wraps from FFFF to 0000
        q0 = idx_q.size();
        start_batch(16'hFFFF, 16'd2);
        wait_idle("t6_wait");
        check("t6_nidx", idx_q.size() - q0, 32'd2);
        check("t6_idx0", {16'd0, (q0 < idx_q.size()) ? idx_q[q0] : 16'hxxxx}, 32'h0000FFFF);
        check("t6_idx1", {16'd0, (q0 + 1 < idx_q.size()) ? idx_q[q0 + 1] : 16'hxxxx}, 32'h00000000);
        check("t6_correct", num_correct, 32'd2);

        // Empty batch: done two cycles after run
        start_batch(16'd5, 16'd0);
        check("t7_done_early", {31'd0, done}, 32'd0);
        check("t7_busy_early", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t7_done", {31'd0, done}, 32'd1);
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_numdone", num_done, 32'd0);
        @(negedge clk);
        check("t7_done_once", {31'd0, done}, 32'd0);

        // Abort during RUN of the third sample
        d0 = ndone;
        start_batch(16'd0, 16'd5);
        for (int i = 0; i < 400 && !(num_done == 32'd2 && nn_start); i++) @(negedge clk);
        check("t8_reached", {31'd0, nn_start}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t8_busy", {31'd0, busy}, 32'd0);
        check("t8_nn_rst", {31'd0, nn_rst}, 32'd1);
        check("t8_nn_start", {31'd0, nn_start}, 32'd0);
        repeat (30) @(negedge clk);
        check("t8_numdone", num_done, 32'd2);
        check("t8_nodone", ndone - d0, 32'd0);

        // Async reset mid-batch
        start_batch(16'd0, 16'd3);
        for (int i = 0; i < 400 && num_done == 32'd0; i++) @(negedge clk);
        check("t9_progress", num_done, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t9_numdone", num_done, 32'd0);
        check("t9_busy", {31'd0, busy}, 32'd0);
        check("t9_nn_rst", {31'd0, nn_rst}, 32'd1);
        check("t9_nn_start", {31'd0, nn_start}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
